// File: rtl/axis_fork_route_ctrl.sv
// ---------------------------------------------------------------------------
// axis_fork_route_ctrl
//  Per-packet route controller for an M_COUNT-port AXI-Stream fork arbiter.
//  It sits on the upstream handshake and drives the arbiter's oen, fork_enable
//  and single_mask. That configuration is held constant for a whole
//  tlast-delimited packet. In fork mode each packet goes to every enabled
//  port. In single mode each packet goes to one enabled port, chosen
//  round-robin. Only handshakes pass through this block; data bypasses it.
//
//  Ports
//   clk, rst_n    rising-edge clock, synchronous active-low reset
//   cfg_oen       requested output-enable mask (sampled at packet start)
//   cfg_fork      1 = broadcast, 0 = round-robin single (sampled at start)
//   up_tvalid     upstream tvalid
//   up_tlast      upstream tlast
//   up_tready     upstream tready, gated by the XFER state (combinational)
//   arb_tvalid    tvalid to the arbiter, gated by XFER (combinational)
//   arb_tready    tready from the arbiter
//   oen           latched enable mask
//   fork_enable   latched mode
//   single_mask   one-hot target in single mode, 0 in fork mode
//   busy          high in SETUP or XFER
//   pkt_count     completed packets, wraps
//   err_no_dest   sticky, set when a packet waits while cfg_oen is zero
// ---------------------------------------------------------------------------
module axis_fork_route_ctrl #(
   parameter int unsigned M_COUNT   = 3,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [M_COUNT-1:0]   cfg_oen,
   input  logic                 cfg_fork,
   input  logic                 up_tvalid,
   input  logic                 up_tlast,
   output logic                 up_tready,
   output logic                 arb_tvalid,
   input  logic                 arb_tready,
   output logic [M_COUNT-1:0]   oen,
   output logic                 fork_enable,
   output logic [M_COUNT-1:0]   single_mask,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] pkt_count,
   output logic                 err_no_dest
);

   localparam int unsigned IDX_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_XFER  = 2'd2;

   logic [1:0]           state_q,       state_d;
   logic [M_COUNT-1:0]   oen_q,         oen_d;
   logic                 fork_q,        fork_d;
   logic [M_COUNT-1:0]   single_mask_q, single_mask_d;
   logic                 busy_q,        busy_d;
   logic [CNT_WIDTH-1:0] pkt_count_q,   pkt_count_d;
   logic                 err_q,         err_d;
   logic [IDX_W-1:0]     rr_last_q,     rr_last_d;

   logic                 rr_found;
   logic [IDX_W-1:0]     rr_idx;
   logic                 in_xfer;
   logic                 last_hs;

   // Next round-robin target: first enabled port after rr_last, wrapping.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int unsigned i = 1; i <= M_COUNT; i++) begin
         if (!rr_found && cfg_oen[IDX_W'((32'(rr_last_q) + i) % M_COUNT)]) begin
            rr_found = 1'b1;
            rr_idx   = IDX_W'((32'(rr_last_q) + i) % M_COUNT);
         end
      end
   end

   // Handshake gating: beats only move in XFER, once configuration is stable.
   assign in_xfer    = (state_q == ST_XFER);
   assign up_tready  = arb_tready & in_xfer;
   assign arb_tvalid = up_tvalid & in_xfer;
   assign last_hs    = in_xfer & up_tvalid & arb_tready & up_tlast;

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      oen_d         = oen_q;
      fork_d        = fork_q;
      single_mask_d = single_mask_q;
      pkt_count_d   = pkt_count_q;
      err_d         = err_q;
      rr_last_d     = rr_last_q;

      case (state_q)
         ST_IDLE: begin
            if (up_tvalid) begin
               if (cfg_oen == '0) begin
                  err_d = 1'b1;
               end else begin
                  oen_d  = cfg_oen;
                  fork_d = cfg_fork;
                  if (cfg_fork) begin
                     single_mask_d = '0;
                  end else begin
                     single_mask_d = M_COUNT'(1) << rr_idx;
                     rr_last_d     = rr_idx;
                  end
                  state_d = ST_SETUP;
               end
            end
         end
         ST_SETUP: state_d = ST_XFER;
         ST_XFER: begin
            if (last_hs) begin
               pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State registers; reset abandons any packet in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         oen_q         <= '0;
         fork_q        <= 1'b0;
         single_mask_q <= '0;
         busy_q        <= 1'b0;
         pkt_count_q   <= '0;
         err_q         <= 1'b0;
         rr_last_q     <= IDX_W'(M_COUNT - 1);
      end else begin
         state_q       <= state_d;
         oen_q         <= oen_d;
         fork_q        <= fork_d;
         single_mask_q <= single_mask_d;
         busy_q        <= busy_d;
         pkt_count_q   <= pkt_count_d;
         err_q         <= err_d;
         rr_last_q     <= rr_last_d;
      end
   end

   assign oen         = oen_q;
   assign fork_enable = fork_q;
   assign single_mask = single_mask_q;
   assign busy        = busy_q;
   assign pkt_count   = pkt_count_q;
   assign err_no_dest = err_q;

endmodule
